// File: rtl/alu_seq.sv
// Registered 16-bit-class ALU with valid/ready handshake and a multi-cycle shift-add multiply.
// Optional status flags are built only when ALU_SEQ_FLAGS_EN is defined; otherwise the flags are tied to 0.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_next;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign ALU_Result = result_q;
  assign busy       = (state_q == MUL);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    acc_next    = acc_q + (mplr_q[0] ? mcand_q : '0);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (ALU_Sel == OP_MUL) begin
            mcand_d     = {{WIDTH{1'b0}}, A};
            mplr_d      = B;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = MUL;
          end else begin
            out_valid_d = 1'b1;
            case (ALU_Sel)
              OP_ADD:  result_d = A + B;
              OP_SUB:  result_d = A - B;
              OP_NOT:  result_d = ~A;
              OP_AND:  result_d = A & B;
              OP_OR:   result_d = A | B;
              OP_XOR:  result_d = A ^ B;
              OP_XNOR: result_d = ~(A ^ B);
              default: ;
            endcase
          end
        end
      end
      MUL: begin
        // One partial product per edge; the last step's add is folded into the result load.
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          result_d    = acc_next[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic       load_op, load_mul;
  logic [3:0] flags_q, flags_d;

  assign load_op  = in_valid && in_ready && (ALU_Sel != OP_MUL);
  assign load_mul = (state_q == MUL) && (cnt_q == LAST_STEP);

  // Flags are {z, n, c, v}; carry on ADD is detected as unsigned wrap of the result.
  always_comb begin
    flags_d = flags_q;
    if (load_op || load_mul) begin
      flags_d[3] = (result_d == '0);
      flags_d[2] = result_d[WIDTH-1];
      flags_d[1] = 1'b0;
      flags_d[0] = 1'b0;
      if (load_mul) begin
        flags_d[1] = |acc_next[2*WIDTH-1:WIDTH];
      end else if (ALU_Sel == OP_ADD) begin
        flags_d[1] = (result_d < A);
        flags_d[0] = (A[WIDTH-1] == B[WIDTH-1]) && (result_d[WIDTH-1] != A[WIDTH-1]);
      end else if (ALU_Sel == OP_SUB) begin
        flags_d[1] = (A < B);
        flags_d[0] = (A[WIDTH-1] != B[WIDTH-1]) && (result_d[WIDTH-1] != A[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flag_z = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed cases plus random operations checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int WIDTH = 16;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in, b_in;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .ALU_Sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Result(alu_result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_flags(input logic [3:0] f);
    return FLAGS_ON ? f : 4'b0000;
  endfunction

  // Reference: plain integer arithmetic; flags returned as {z, n, c, v}.
  function automatic void ref_model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] r, output logic [3:0] f);
    int    ua, ub, sa, sb, s;
    longint p;
    logic  c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[WIDTH-1] ? ua - 65536 : ua;
    sb = b[WIDTH-1] ? ub - 65536 : ub;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin s = ua + ub; r = s[15:0]; c = (s > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd1: begin s = ua - ub; r = s[15:0]; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: begin p = longint'(ua) * longint'(ub); r = p[15:0]; c = (p > 65535); end
    endcase
    f = mask_flags({(r == '0), r[WIDTH-1], c, v});
  endfunction

  // Issue one op, wait for its result, check it, then optionally stall the consumer for 'hold' cycles.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] exp_r, input logic [3:0] exp_f,
                               input int hold, input string tag);
    int cycles;
    bit bad;
    sel = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    sel  = 3'($urandom);
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    if (op == 3'b111) begin
      cycles = 0;
      bad    = 1'b0;
      while (!out_valid && cycles < 64) begin
        if (!busy || in_ready) bad = 1'b1;
        tick();
        cycles++;
      end
      checkOutput({tag, " mul latency"}, 32'(cycles), 32'(WIDTH));
      checkOutput({tag, " busy/in_ready during mul"}, 32'(bad), 32'd0);
      checkOutput({tag, " busy after mul"}, 32'(busy), 32'd0);
    end
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " result"}, 32'(alu_result), 32'(exp_r));
    checkOutput({tag, " flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_f));
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 3'($urandom);
      repeat (hold) tick();
      checkOutput({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " held result"}, 32'(alu_result), 32'(exp_r));
      checkOutput({tag, " held flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(exp_f));
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] er, ra, rb;
    logic [3:0]       ef;
    logic [2:0]       rop;
    int               hold;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; sel = '0;
    #1;
    checkOutput("reset result", 32'(alu_result), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
    tick();

    applyStimulus(3'b000, 16'hFFFF, 16'h0001, 16'h0000, mask_flags(4'b1010), 0, "add wrap");
    tick();
    checkOutput("add out_valid one cycle", 32'(out_valid), 32'd0);

    applyStimulus(3'b001, 16'h8000, 16'h0001, 16'h7FFF, mask_flags(4'b0001), 0, "sub ovf");
    applyStimulus(3'b001, 16'h0001, 16'h0002, 16'hFFFF, mask_flags(4'b0110), 0, "sub borrow");
    applyStimulus(3'b111, 16'h0123, 16'h0010, 16'h1230, mask_flags(4'b0000), 0, "mul small");
    applyStimulus(3'b111, 16'h8000, 16'h0002, 16'h0000, mask_flags(4'b1010), 0, "mul carry");

    applyStimulus(3'b110, 16'h00FF, 16'h0F0F, 16'hF00F, mask_flags(4'b0100), 5, "xnor hold");
    applyStimulus(3'b011, 16'hFFFF, 16'h00F0, 16'h00F0, mask_flags(4'b0000), 0, "and after hold");

    // Async reset mid-cycle while a result is still being held.
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midcycle reset result", 32'(alu_result), 32'd0);
    checkOutput("midcycle reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midcycle reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Abandon a multiply partway through with an async reset.
    sel = 3'b111; a_in = 16'h1234; b_in = 16'h5678; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    checkOutput("mul busy before abort", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mul abort busy", 32'(busy), 32'd0);
    checkOutput("mul abort out_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    tick();
    applyStimulus(3'b000, 16'h0002, 16'h0003, 16'h0005, mask_flags(4'b0000), 0, "add after abort");

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = 16'h0000; 1: ra = 16'hFFFF; 2: ra = 16'h8000; 3: ra = 16'h7FFF;
        default: ra = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rb = 16'h0000; 1: rb = 16'hFFFF; 2: rb = 16'h8000; 3: rb = 16'h0001;
        default: rb = WIDTH'($urandom);
      endcase
      hold = $urandom_range(0, 2);
      ref_model(rop, ra, rb, er, ef);
      applyStimulus(rop, ra, rb, er, ef, hold, $sformatf("rand%0d op%0d", i, rop));
    end

    tick();
    checkOutput("final idle out_valid", 32'(out_valid), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
